// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the 3x3 window frame sequencer.
package frame_seq_pkg;

  typedef enum logic [2:0] {IDLE, FILL, STREAM, DRAIN, DONE} state_e;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  // Shifts between a pixel entering the window and it becoming the centre.
  localparam int LAG       = IMG_W_DEF + 1;

  localparam int ROW_W = 9;
  localparam int COL_W = 10;
  localparam int DRN_W = 11;

  function automatic int lag_of(input int img_w);
    return img_w + 1;
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Host-side pixel handshake and window-result signals of the frame sequencer.
interface frame_sequencer_if;
  import frame_seq_pkg::*;

  logic             start;
  logic             pix_valid;
  logic             pix_ready;
  logic             shift_en;
  logic             pad;
  logic             out_valid;
  logic             border;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, pix_valid,
    input  pix_ready, shift_en, pad, out_valid, border, out_row, out_col, busy, frame_done
  );

  modport slave (
    input  start, pix_valid,
    output pix_ready, shift_en, pad, out_valid, border, out_row, out_col, busy, frame_done
  );

endinterface

// File: rtl/seq_delay_line.sv
// Aligns window-result qualifiers with the PIPE_DLY-cycle window datapath.
module seq_delay_line
  import frame_seq_pkg::*;
#(
  parameter int PIPE_DLY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vld_in,
  input  logic             brd_in,
  input  logic [ROW_W-1:0] row_in,
  input  logic [COL_W-1:0] col_in,
  output logic             vld_out,
  output logic             brd_out,
  output logic [ROW_W-1:0] row_out,
  output logic [COL_W-1:0] col_out
);

  localparam int WIDTH = 2 + ROW_W + COL_W;

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  assign din = {vld_in, brd_in, row_in, col_in};
  assign {vld_out, brd_out, row_out, col_out} = dout;

  if (PIPE_DLY == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [PIPE_DLY];
    logic [WIDTH-1:0] stage_d [PIPE_DLY];

    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < PIPE_DLY; i++) stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DLY; i++) stage_q[i] <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[PIPE_DLY-1];
  end

endmodule

// File: rtl/frame_sequencer.sv
// Raster sequencer for a 3x3 window filter: fill, stream, zero-pad drain.
// Define BORDER_ZERO_EN to emit edge pixels (flagged border) instead of dropping them.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int PIPE_DLY = 2
) (
  input  logic               clk,
  input  logic               reset,
  frame_sequencer_if.slave   bus
);

  localparam int               LAG_N      = lag_of(IMG_W);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(IMG_H - 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(LAG_N - 1);
  localparam logic [DRN_W-1:0] DRAIN_END  = DRN_W'(LAG_N - 1 + PIPE_DLY);

  state_e           state_q, state_d;
  logic [COL_W-1:0] in_col_q, in_col_d, ccol_q, ccol_d;
  logic [ROW_W-1:0] in_row_q, in_row_d, crow_q, crow_d;
  logic [DRN_W-1:0] drain_q, drain_d;

  logic pix_ready, accept, drain_shift, complete, on_edge, vld_in, brd_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      in_col_q <= '0;
      in_row_q <= '0;
      ccol_q   <= '0;
      crow_q   <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      ccol_q   <= ccol_d;
      crow_q   <= crow_d;
      drain_q  <= drain_d;
    end
  end

  always_comb begin
    pix_ready   = (state_q == FILL) || (state_q == STREAM);
    accept      = bus.pix_valid && pix_ready;
    drain_shift = (state_q == DRAIN) && (drain_q <= DRAIN_LAST);
    // Once the window is full every shift retires exactly one centre pixel.
    complete    = (accept && (state_q == STREAM)) || drain_shift;

    state_d  = state_q;
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    ccol_d   = ccol_q;
    crow_d   = crow_q;
    drain_d  = drain_q;

    if (accept) begin
      if (in_col_q == LAST_COL) begin
        in_col_d = '0;
        in_row_d = in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end

    if (complete) begin
      if (ccol_q == LAST_COL) begin
        ccol_d = '0;
        crow_d = crow_q + 1'b1;
      end else begin
        ccol_d = ccol_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = FILL;
          in_col_d = '0;
          in_row_d = '0;
          ccol_d   = '0;
          crow_d   = '0;
          drain_d  = '0;
        end
      end
      // Accept index IMG_W sits at row 1, column 0: the window is then primed.
      FILL:   if (accept && (in_row_q == ROW_W'(1)) && (in_col_q == '0)) state_d = STREAM;
      STREAM: begin
        if (accept && (in_row_q == LAST_ROW) && (in_col_q == LAST_COL)) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      // Pad shifts first, then wait out the datapath latency for the last result.
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_END) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign on_edge = (crow_q == '0) || (crow_q == LAST_ROW) ||
                   (ccol_q == '0) || (ccol_q == LAST_COL);

`ifdef BORDER_ZERO_EN
  assign vld_in = complete;
  assign brd_in = on_edge;
`else
  assign vld_in = complete && !on_edge;
  assign brd_in = 1'b0;
`endif

  assign bus.pix_ready  = pix_ready;
  assign bus.shift_en   = accept || drain_shift;
  assign bus.pad        = drain_shift;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = (state_q == DONE);

  seq_delay_line #(
    .PIPE_DLY (PIPE_DLY)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .vld_in  (vld_in),
    .brd_in  (brd_in),
    .row_in  (crow_q),
    .col_in  (ccol_q),
    .vld_out (bus.out_valid),
    .brd_out (bus.border),
    .row_out (bus.out_row),
    .col_out (bus.out_col)
  );

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a 4x4 image with a 2-cycle window pipeline.
module tb_frame_sequencer;
  import frame_seq_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam int D = 2;
`ifdef BORDER_ZERO_EN
  localparam bit BZ = 1'b1;
`else
  localparam bit BZ = 1'b0;
`endif
  localparam int EXP_OUT = BZ ? 16 : 4;
  localparam int EXP_BRD = BZ ? 12 : 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_sequencer_if bus();

  frame_sequencer #(.IMG_W(W), .IMG_H(H), .PIPE_DLY(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int n_acc, n_out, n_brd, n_pad, n_done, n_orphan, n_shbad;
  int acc_cyc [64];
  int out_cyc [64];
  logic [8:0] o_row [64];
  logic [9:0] o_col [64];
  logic       o_brd [64];
  logic [1:0] sh_hist;

  always @(negedge clk) begin
    cyc++;
    if (bus.pix_valid && bus.pix_ready) begin
      if (n_acc < 64) acc_cyc[n_acc] = cyc;
      n_acc++;
    end
    if (bus.shift_en && bus.pad) n_pad++;
    if (bus.shift_en !== ((bus.pix_valid && bus.pix_ready) || bus.pad)) n_shbad++;
    if (bus.out_valid) begin
      if (n_out < 64) begin
        out_cyc[n_out] = cyc;
        o_row[n_out]   = bus.out_row;
        o_col[n_out]   = bus.out_col;
        o_brd[n_out]   = bus.border;
      end
      n_out++;
      if (bus.border) n_brd++;
      if (!sh_hist[1]) n_orphan++;
    end
    if (bus.frame_done) n_done++;
    sh_hist = {sh_hist[0], bus.shift_en};
  end

  task automatic clear_mon();
    n_acc = 0; n_out = 0; n_brd = 0; n_pad = 0; n_done = 0; n_orphan = 0; n_shbad = 0;
    sh_hist = '0;
    for (int i = 0; i < 64; i++) begin
      o_row[i] = 'x; o_col[i] = 'x; o_brd[i] = 1'bx; acc_cyc[i] = -100; out_cyc[i] = -1;
    end
  endtask

  // Runs one frame; pix_valid stays asserted (or toggling) through drain to prove it is ignored.
  task automatic drive_frame(input bit toggle, input int extra_start_at);
    int guard;
    clear_mon();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    guard = 0;
    while (n_done == 0 && guard < 400) begin
      bus.pix_valid = toggle ? ~bus.pix_valid : 1'b1;
      bus.start = (extra_start_at > 0 && n_acc == extra_start_at) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    bus.pix_valid = 1'b0;
    bus.start = 1'b0;
    n_cmp++;
    if (n_done == 0) begin
      n_bad++;
      $display("FAIL frame_timeout: frame_done count %0d after %0d cycles, required 1", n_done, guard);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_order(input string tag);
    int idx = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (BZ || (r > 0 && r < H-1 && c > 0 && c < W-1)) begin
          logic exp_b;
          exp_b = BZ && (r == 0 || r == H-1 || c == 0 || c == W-1);
          n_cmp++;
          if (o_row[idx] !== 9'(r) || o_col[idx] !== 10'(c) || o_brd[idx] !== exp_b) begin
            n_bad++;
            $display("FAIL %s_order[%0d]: got row %0d col %0d border %b, required row %0d col %0d border %b",
                     tag, idx, o_row[idx], o_col[idx], o_brd[idx], r, c, exp_b);
          end
          idx++;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.pix_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.pix_ready, bus.shift_en, bus.pad, bus.out_valid, bus.border, bus.busy, bus.frame_done} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {bus.pix_ready, bus.shift_en, bus.pad, bus.out_valid, bus.border, bus.busy, bus.frame_done});
    end
    n_cmp++;
    if (bus.out_row !== 9'd0 || bus.out_col !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_pos: got row %0d col %0d, required 0 0", bus.out_row, bus.out_col);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.pix_ready !== 1'b0 || bus.busy !== 1'b0 || bus.shift_en !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ignore_valid: got ready %b busy %b shift %b, required 0 0 0",
               bus.pix_ready, bus.busy, bus.shift_en);
    end
    bus.pix_valid = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.pix_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL start_to_fill: got busy %b ready %b, required 1 1", bus.busy, bus.pix_ready);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_first_out();
    int k;
    drive_frame(1'b0, 0);
    k = BZ ? 0 : W + 1;
    n_cmp++;
    if (out_cyc[0] - acc_cyc[k + W + 1] !== D) begin
      n_bad++;
      $display("FAIL first_latency: got %0d cycles, required %0d", out_cyc[0] - acc_cyc[k + W + 1], D);
    end
    n_cmp++;
    if (o_row[0] !== 9'(k / W) || o_col[0] !== 10'(k % W) || o_brd[0] !== BZ) begin
      n_bad++;
      $display("FAIL first_pos: got row %0d col %0d border %b, required row %0d col %0d border %b",
               o_row[0], o_col[0], o_brd[0], k / W, k % W, BZ);
    end
  endtask

  task automatic test_full_frame();
    drive_frame(1'b0, 0);
    n_cmp++;
    if (n_acc !== W*H) begin n_bad++; $display("FAIL full_accepts: got %0d, required %0d", n_acc, W*H); end
    n_cmp++;
    if (n_out !== EXP_OUT) begin n_bad++; $display("FAIL full_outputs: got %0d, required %0d", n_out, EXP_OUT); end
    n_cmp++;
    if (n_brd !== EXP_BRD) begin n_bad++; $display("FAIL full_border: got %0d, required %0d", n_brd, EXP_BRD); end
    n_cmp++;
    if (n_pad !== W + 1) begin n_bad++; $display("FAIL full_pads: got %0d, required %0d", n_pad, W + 1); end
    n_cmp++;
    if (n_done !== 1) begin n_bad++; $display("FAIL full_done: got %0d pulses, required 1", n_done); end
    n_cmp++;
    if (n_shbad !== 0) begin n_bad++; $display("FAIL full_shift_en: got %0d bad cycles, required 0", n_shbad); end
    check_order("full");
  endtask

  task automatic test_toggle();
    drive_frame(1'b1, 0);
    n_cmp++;
    if (n_acc !== W*H) begin n_bad++; $display("FAIL toggle_accepts: got %0d, required %0d", n_acc, W*H); end
    n_cmp++;
    if (n_out !== EXP_OUT) begin n_bad++; $display("FAIL toggle_outputs: got %0d, required %0d", n_out, EXP_OUT); end
    n_cmp++;
    if (n_orphan !== 0) begin n_bad++; $display("FAIL toggle_orphan: got %0d, required 0", n_orphan); end
    n_cmp++;
    if (n_done !== 1) begin n_bad++; $display("FAIL toggle_done: got %0d pulses, required 1", n_done); end
    check_order("toggle");
  endtask

  task automatic test_start_in_stream();
    drive_frame(1'b0, 8);
    n_cmp++;
    if (n_acc !== W*H) begin n_bad++; $display("FAIL restart_accepts: got %0d, required %0d", n_acc, W*H); end
    n_cmp++;
    if (n_out !== EXP_OUT) begin n_bad++; $display("FAIL restart_outputs: got %0d, required %0d", n_out, EXP_OUT); end
    n_cmp++;
    if (n_pad !== W + 1 || n_done !== 1) begin
      n_bad++;
      $display("FAIL restart_drain: got pads %0d done %0d, required %0d 1", n_pad, n_done, W + 1);
    end
    check_order("restart");
  endtask

  task automatic test_reset_mid();
    int guard;
    clear_mon();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.pix_valid = 1'b1;
    guard = 0;
    while (n_acc < 9 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++;
    if (n_acc !== 9) begin n_bad++; $display("FAIL mid_accepts: got %0d, required 9", n_acc); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.pix_ready, bus.shift_en, bus.pad, bus.out_valid, bus.border, bus.busy, bus.frame_done} !== 7'b0
        || bus.out_row !== 9'd0 || bus.out_col !== 10'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got ctrl %b row %0d col %0d, required 0",
               {bus.pix_ready, bus.shift_en, bus.pad, bus.out_valid, bus.border, bus.busy, bus.frame_done},
               bus.out_row, bus.out_col);
    end
    @(posedge clk); #1;
    clear_mon();
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (n_acc !== 0 || n_out !== 0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_after_reset: got accepts %0d outputs %0d busy %b, required 0 0 0", n_acc, n_out, bus.busy);
    end
    bus.pix_valid = 1'b0;
    drive_frame(1'b0, 0);
    n_cmp++;
    if (n_out !== EXP_OUT) begin n_bad++; $display("FAIL mid_rerun_outputs: got %0d, required %0d", n_out, EXP_OUT); end
    check_order("rerun");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    reset = 1'b1;
    clear_mon();
    test_reset();
    test_first_out();
    test_full_frame();
    test_toggle();
    test_start_in_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
